// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving a registered one-cycle regfile write pulse, with load extension
module wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_is_load,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [31:0]      in_result,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    output logic             rf_load,
    output logic [4:0]       rf_dest,
    output logic [31:0]      rf_wdata,
    output logic             rf_valid_forward,
    output logic [CNT_W-1:0] retired,
    output logic             spurious_resp
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state_q, state_d;
    logic [4:0] rd_q, rd_d;
    logic [2:0] funct3_q, funct3_d;
    logic [1:0] addr_q, addr_d;
    logic load_q, load_d;
    logic [4:0] dest_q, dest_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] retired_q;
    logic spurious_q, retire;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_v;
    assign byte_v = 8'(dmem_rdata >> {addr_q, 3'b000});
    assign half_v = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign ext_v = funct3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                   funct3_q == 3'b100 ? {24'b0, byte_v} :
                   funct3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                   funct3_q == 3'b101 ? {16'b0, half_v} : dmem_rdata;
    assign in_ready = state_q == IDLE;
    always_comb begin
        state_d = state_q;
        rd_d = rd_q;
        funct3_d = funct3_q;
        addr_d = addr_q;
        load_d = 1'b0;
        dest_d = dest_q;
        wdata_d = wdata_q;
        retire = 1'b0;
        if (state_q == IDLE && in_valid) begin
            if (in_is_load) begin
                rd_d = in_rd;
                funct3_d = in_funct3;
                addr_d = in_addr_lo;
                state_d = WAIT_MEM;
            end else begin
                dest_d = in_rd;
                wdata_d = in_result;
                load_d = in_rd != 5'd0;
                retire = 1'b1;
            end
        end else if (state_q == WAIT_MEM && dmem_resp) begin
            dest_d = rd_q;
            wdata_d = ext_v;
            load_d = rd_q != 5'd0;
            retire = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q <= '0;
            funct3_q <= '0;
            addr_q <= '0;
            load_q <= 1'b0;
            dest_q <= '0;
            wdata_q <= '0;
            retired_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q <= rd_d;
            funct3_q <= funct3_d;
            addr_q <= addr_d;
            load_q <= load_d;
            dest_q <= dest_d;
            wdata_q <= wdata_d;
            retired_q <= retired_q + CNT_W'(retire);
            spurious_q <= spurious_q | (dmem_resp && state_q == IDLE);
        end
    end
    assign rf_load = load_q;
    assign rf_valid_forward = load_q;
    assign rf_dest = dest_q;
    assign rf_wdata = wdata_q;
    assign retired = retired_q;
    assign spurious_resp = spurious_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage
module tb_wb_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_is_load = 1'b0, dmem_resp = 1'b0;
    logic [4:0] in_rd = '0;
    logic [2:0] in_funct3 = '0;
    logic [1:0] in_addr_lo = '0;
    logic [31:0] in_result = '0, dmem_rdata = '0;
    logic in_ready, rf_load, rf_valid_forward, spurious_resp;
    logic [4:0] rf_dest;
    logic [31:0] rf_wdata;
    logic [63:0] retired;
    typedef struct packed {logic ld; logic [4:0] d; logic [31:0] w;} exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    logic [63:0] exp_ret = '0;
    always #5 clk = ~clk;
    wb_stage #(.CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .in_result(in_result), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .rf_load(rf_load), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
        .rf_valid_forward(rf_valid_forward), .retired(retired), .spurious_resp(spurious_resp)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [7:0] b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000: return {{24{b[7]}}, b};
            3'b100: return {24'h0, b};
            3'b001: return {{16{h[15]}}, h};
            3'b101: return {16'h0, h};
            default: return w;
        endcase
    endfunction
    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_load"}, rf_load, e.ld);
        chk({tag, "_fwd"}, rf_valid_forward, e.ld);
        chk({tag, "_dest"}, rf_dest, e.d);
        chk({tag, "_wdata"}, rf_wdata, e.w);
        chk({tag, "_retired"}, retired, exp_ret);
    endtask
    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
        in_valid = 1'b1;
        in_is_load = 1'b0;
        in_rd = rd;
        in_result = res;
        sb.push_back('{ld: rd != 0, d: rd, w: res});
        exp_ret++;
    endtask
    task automatic alu(input string tag, input logic [4:0] rd, input logic [31:0] res);
        @(negedge clk);
        drive_alu(rd, res);
        @(negedge clk);
        in_valid = 1'b0;
        pop_chk(tag);
        chk({tag, "_ready"}, in_ready, 1);
        @(negedge clk);
        chk({tag, "_pulse_end"}, rf_load, 0);
        chk({tag, "_dest_hold"}, rf_dest, rd);
    endtask
    task automatic load(input string tag, input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                        input logic [31:0] w, input int dly, input logic [31:0] exp_w, input bit tail);
        @(negedge clk);
        in_valid = 1'b1;
        in_is_load = 1'b1;
        in_rd = rd;
        in_funct3 = f3;
        in_addr_lo = a;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_nowrite"}, rf_load, 0);
        for (int i = 1; i < dly; i++) begin
            chk({tag, "_wait_ready"}, in_ready, 0);
            @(negedge clk);
        end
        chk({tag, "_wait_ready"}, in_ready, 0);
        dmem_resp = 1'b1;
        dmem_rdata = w;
        sb.push_back('{ld: rd != 0, d: rd, w: exp_w});
        exp_ret++;
        @(negedge clk);
        dmem_resp = 1'b0;
        pop_chk(tag);
        chk({tag, "_ready_back"}, in_ready, 1);
        if (tail) begin
            @(negedge clk);
            chk({tag, "_pulse_end"}, rf_load, 0);
        end
    endtask
    initial begin
        logic [2:0] f3s [6];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_load", rf_load, 0);
        chk("rst_fwd", rf_valid_forward, 0);
        chk("rst_dest", rf_dest, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_retired", retired, 0);
        chk("rst_spur", spurious_resp, 0);
        alu("alu5", 5'd5, 32'hDEADBEEF);
        load("lb", 5'd3, 3'b000, 2'd2, 32'h12F45678, 3, 32'hFFFFFFF4, 1);
        load("lbu", 5'd3, 3'b100, 2'd2, 32'h12F45678, 3, 32'h000000F4, 1);
        load("lh", 5'd7, 3'b001, 2'd3, 32'h80017FFF, 2, 32'hFFFF8001, 1);
        load("lhu", 5'd8, 3'b101, 2'd0, 32'h80017FFF, 1, 32'h00007FFF, 1);
        load("lw", 5'd9, 3'b010, 2'd1, 32'h80017FFF, 2, 32'h80017FFF, 1);
        alu("alu0", 5'd0, 32'h1);
        load("b2b_ld", 5'd10, 3'b000, 2'd1, 32'h0000_8000, 2, 32'hFFFFFF80, 0);
        drive_alu(5'd11, 32'hCAFEF00D);
        @(negedge clk);
        in_valid = 1'b0;
        pop_chk("b2b_alu");
        @(negedge clk);
        chk("b2b_pulse_end", rf_load, 0);
        for (int k = 0; k < 10; k++) begin
            logic [4:0] rd;
            logic [2:0] f3;
            logic [1:0] a;
            logic [31:0] w;
            rd = 5'($urandom_range(0, 31));
            f3 = f3s[$urandom_range(0, 5)];
            a = 2'($urandom);
            w = $urandom;
            load("rnd", rd, f3, a, w, $urandom_range(1, 4), ext(f3, a, w), 1);
        end
        chk("spur_pre", spurious_resp, 0);
        @(negedge clk);
        dmem_resp = 1'b1;
        dmem_rdata = 32'h5555AAAA;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("spur_set", spurious_resp, 1);
        chk("spur_nowrite", rf_load, 0);
        chk("spur_noret", retired, exp_ret);
        repeat (3) @(negedge clk);
        chk("spur_sticky", spurious_resp, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = '0;
        chk("spur_clr", spurious_resp, 0);
        chk("rst2_retired", retired, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_is_load = 1'b1;
        in_rd = 5'd4;
        in_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_wait", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_ready", in_ready, 1);
        chk("mid_load", rf_load, 0);
        chk("mid_dest", rf_dest, 0);
        chk("mid_wdata", rf_wdata, 0);
        chk("mid_retired", retired, 0);
        dmem_resp = 1'b1;
        dmem_rdata = 32'h11111111;
        @(negedge clk);
        dmem_resp = 1'b0;
        chk("late_nowrite", rf_load, 0);
        chk("late_spur", spurious_resp, 1);
        chk("late_retired", retired, 0);
        alu("post_alu", 5'd31, 32'h0BADF00D);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
